ame_comp_sched: RTL

Shares one pipelined `ame_num_compare` instance between `REQ_NUM` affine motion estimation cost requesters. Each requester submits a set of six candidate costs. The block arbitrates round-robin, issues at most one set per cycle to the comparator, and tags every issue so the minimum value and its index return to the requester that asked. Each requester has at most one set in flight, so no result ever needs a queue deeper than one entry.

---
 rtl/ame_comp_sched_pkg.sv | 20 ++
 rtl/ame_rr_arbiter.sv | 40 ++++
 rtl/ame_comp_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ame_comp_sched_pkg.sv
// Shared types for the AME comparator scheduler: requester FSM states and
// the tag that travels alongside each comparator issue.
package ame_comp_sched_pkg;

    // Tag index field is sized generously so the tag type does not depend on REQ_NUM.
    localparam int TAG_IDX_BITS = 8;
    localparam int COMP_NUM_IN  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } req_state_t;

    typedef struct packed {
        logic                    vld;
        logic [TAG_IDX_BITS-1:0] idx;
    } comp_tag_t;

endpackage

// File: rtl/ame_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; the search starts at ptr,
// which moves just past the winner after every grant.
module ame_rr_arbiter #(
    parameter int REQ_NUM      = 4,
    parameter int REQ_IDX_BITS = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [REQ_NUM-1:0]      req_i,
    output logic [REQ_NUM-1:0]      gnt_o,
    output logic [REQ_IDX_BITS-1:0] gnt_idx_o
);

    logic [REQ_IDX_BITS-1:0] ptr_q, ptr_d;

    always_comb begin
        int   cand;
        logic found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            cand = (int'(ptr_q) + i) % REQ_NUM;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = REQ_IDX_BITS'(cand);
            end
        end
        ptr_d = ptr_q;
        if (found) ptr_d = REQ_IDX_BITS'((int'(gnt_idx_o) + 1) % REQ_NUM);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ame_comp_sched.sv
// Shares one pipelined min-comparator among REQ_NUM requesters; a tag pipeline
// matched to the comparator latency routes each result back to its requester.
module ame_comp_sched
    import ame_comp_sched_pkg::*;
#(
    parameter int REQ_NUM            = 4,
    parameter int REQ_IDX_BITS       = 2,
    parameter int COMP_DATA_BITS     = 64,
    parameter int COMP_DATA_IDX_BITS = 3,
    parameter int COMP_LATENCY       = 3
) (
    input  logic                                              clk_i,
    input  logic                                              rst_n_i,
    input  logic [REQ_NUM-1:0]                                req_valid_i,
    output logic [REQ_NUM-1:0]                                req_ready_o,
    input  logic [REQ_NUM-1:0][COMP_NUM_IN-1:0][COMP_DATA_BITS-1:0] req_data_i,
    output logic [REQ_NUM-1:0]                                rsp_valid_o,
    input  logic [REQ_NUM-1:0]                                rsp_ready_i,
    output logic [REQ_NUM-1:0][COMP_DATA_BITS-1:0]            rsp_data_o,
    output logic [REQ_NUM-1:0][COMP_DATA_IDX_BITS-1:0]        rsp_data_idx_o,
    output logic                                              comp_init_o,
    output logic [COMP_NUM_IN-1:0][COMP_DATA_BITS-1:0]        comp_data_o,
    input  logic                                              comp_done_i,
    input  logic [COMP_DATA_BITS-1:0]                         comp_data_i,
    input  logic [COMP_DATA_IDX_BITS-1:0]                     comp_data_idx_i,
    output logic                                              busy_o,
    output logic                                              err_o
);

    req_state_t state_q [REQ_NUM];
    req_state_t state_d [REQ_NUM];

    logic [REQ_NUM-1:0]                               elig, gnt, cap;
    logic [REQ_IDX_BITS-1:0]                          gnt_idx;
    logic                                             hs;
    logic                                             comp_init_q, comp_init_d;
    logic [COMP_NUM_IN-1:0][COMP_DATA_BITS-1:0]       comp_data_q, comp_data_d;
    logic [REQ_IDX_BITS-1:0]                          issue_idx_q, issue_idx_d;
    comp_tag_t                                        tag_pipe_q [COMP_LATENCY];
    comp_tag_t                                        tag_pipe_d [COMP_LATENCY];
    comp_tag_t                                        tag_out;
    logic [REQ_NUM-1:0][COMP_DATA_BITS-1:0]           rsp_data_q, rsp_data_d;
    logic [REQ_NUM-1:0][COMP_DATA_IDX_BITS-1:0]       rsp_idx_q, rsp_idx_d;
    logic                                             err_q, err_d;

    // Ready is gated by reset so nothing is accepted while the block is held in reset.
    always_comb begin
        for (int r = 0; r < REQ_NUM; r++)
            elig[r] = rst_n_i & req_valid_i[r] & (state_q[r] == IDLE);
    end

    ame_rr_arbiter #(
        .REQ_NUM      (REQ_NUM),
        .REQ_IDX_BITS (REQ_IDX_BITS)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (elig),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready_o = gnt;
    assign hs          = |gnt;
    assign tag_out     = tag_pipe_q[COMP_LATENCY-1];

    // The tag enters the pipe one cycle after issue so its exit lines up with comp_done_i.
    always_comb begin
        comp_init_d = hs;
        comp_data_d = hs ? req_data_i[gnt_idx] : comp_data_q;
        issue_idx_d = hs ? gnt_idx : issue_idx_q;
        tag_pipe_d[0].vld = comp_init_q;
        tag_pipe_d[0].idx = TAG_IDX_BITS'(issue_idx_q);
        for (int k = 1; k < COMP_LATENCY; k++) tag_pipe_d[k] = tag_pipe_q[k-1];
        err_d = err_q | (comp_done_i != tag_out.vld);
        for (int r = 0; r < REQ_NUM; r++) begin
            cap[r]       = comp_done_i & tag_out.vld & (int'(tag_out.idx) == r);
            rsp_data_d[r] = cap[r] ? comp_data_i : rsp_data_q[r];
            rsp_idx_d[r]  = cap[r] ? comp_data_idx_i : rsp_idx_q[r];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            comp_init_q <= 1'b0;
            comp_data_q <= '0;
            issue_idx_q <= '0;
            for (int k = 0; k < COMP_LATENCY; k++) tag_pipe_q[k] <= '0;
            rsp_data_q  <= '0;
            rsp_idx_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            comp_init_q <= comp_init_d;
            comp_data_q <= comp_data_d;
            issue_idx_q <= issue_idx_d;
            for (int k = 0; k < COMP_LATENCY; k++) tag_pipe_q[k] <= tag_pipe_d[k];
            rsp_data_q  <= rsp_data_d;
            rsp_idx_q   <= rsp_idx_d;
            err_q       <= err_d;
        end
    end

    // Requester FSMs: state register / next state / outputs.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < REQ_NUM; r++) begin
            if (!rst_n_i) state_q[r] <= IDLE;
            else          state_q[r] <= state_d[r];
        end
    end

    always_comb begin
        for (int r = 0; r < REQ_NUM; r++) begin
            state_d[r] = state_q[r];
            unique case (state_q[r])
                IDLE:    if (gnt[r])         state_d[r] = WAIT;
                WAIT:    if (cap[r])         state_d[r] = HOLD;
                HOLD:    if (rsp_ready_i[r]) state_d[r] = IDLE;
                default:                     state_d[r] = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int r = 0; r < REQ_NUM; r++) begin
            rsp_valid_o[r] = (state_q[r] == HOLD);
            busy_o         = busy_o | (state_q[r] != IDLE);
        end
    end

    assign comp_init_o    = comp_init_q;
    assign comp_data_o    = comp_data_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_data_idx_o = rsp_idx_q;
    assign err_o          = err_q;

endmodule
